packet_drain: RTL and testbench
===============================

# packet_drain

Downstream consumer of the packet reassembly buffer. Takes the completed packet at the head of the buffer's completed-index queue, streams its flits in order to the local core side with a valid/ready handshake, then pulses `transfered_packet_completed` so the buffer frees the entry and pops the queue. Malformed or incomplete entries are discarded without output and counted.

## Interface
Parameters:
- MAX_FLITS, packet_types::MAX_FLIT_NUM, flit capacity of one packet element; the legal `tail_index` range is 1..MAX_FLITS.
- COUNT_WIDTH, 16, width of the statistics counters.

Ports:
- nocclk  in  1  single clock; everything is on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- transfered_packet  in  packet_types::packet_element_t  head completed packet; stable while `transfered_packet_valid` is high and not yet completed.
- transfered_packet_valid  in  1  a completed packet is available.
- transfered_packet_completed  out  1  one-cycle pulse: the packet was drained or discarded.
- out_flit  out  types::flit_t  current flit to the core side.
- out_flit_valid  out  1  `out_flit` is valid.
- out_flit_ready  in  1  the core side accepts the flit.
- out_flit_last  out  1  marks the final flit of the packet; only meaningful while valid.
- out_packet_id  out  types::packet_id_t  id of the packet being streamed.
- busy  out  1  FSM is not IDLE.
- drained_count  out  COUNT_WIDTH  packets fully streamed; saturating.
- discard_count  out  COUNT_WIDTH  packets discarded; saturating.

## Operation
- FSM states: IDLE, STREAM, DONE, DISCARD.
- **IDLE**
  - On `transfered_packet_valid`:
    - If `is_complete==0`, or `tail_index==0`, or `tail_index>MAX_FLITS`, go to DISCARD.
    - Otherwise latch `len=tail_index` and `packet_id`, load `out_flit<=buffer[0]`, set `idx<=0`, and go to STREAM.
- **STREAM**
  - `out_flit_valid=1`.
  - `out_flit_last=(idx==len-1)`.
  - On handshake (valid & ready):
    - If last, drop valid and go to DONE.
    - Otherwise `idx<=idx+1` and `out_flit<=buffer[idx+1]` on the same edge, giving back-to-back beats.
- **DONE**
  - `transfered_packet_completed=1` for exactly this cycle.
  - `drained_count++`.
  - Go to IDLE.
- **DISCARD**
  - `transfered_packet_completed=1` for exactly this cycle.
  - `discard_count++`.
  - No `out_flit_valid`.
  - Go to IDLE.
- `transfered_packet_completed` is combinational from state: high in DONE or DISCARD only. It is never asserted while `transfered_packet_valid` is low.
- `idx` and `len` widths are `$clog2(MAX_FLITS+1)`. `idx` never exceeds `len-1`, so there is no wrap.
- Counters saturate at all-ones and never roll over.
- `out_packet_id` holds its latched value from STREAM until the next packet is latched.

## Timing
- Reset values:
  - state=IDLE
  - `out_flit='0`, `out_flit_valid=0`, `out_flit_last=0`
  - `out_packet_id=0`, `busy=0`
  - `transfered_packet_completed=0`
  - both counters 0
- Latency:
  - `transfered_packet_valid` seen in IDLE at cycle t gives first `out_flit_valid` at t+1.
  - Discard: completed pulse at t+1.
- Throughput:
  - N flits with ready held high: beats at t+1..t+N, completed at t+N+1, IDLE at t+N+2.
  - The next packet's first flit appears at t+N+3.
- Handshake rules:
  - While `out_flit_valid && !out_flit_ready`, `out_flit`, `out_flit_last` and `idx` hold stable.
  - Valid never drops without a handshake.
- The entry is not freed until DONE. Input is therefore assumed stable through STREAM; the block reads `buffer[idx+1]` directly and keeps no copy.
- Simultaneous events:
  - A handshake on the last beat and a new `transfered_packet_valid` in the same cycle do not start a new packet. The new packet is only examined in IDLE.
- Reset mid-operation:
  - All outputs return to reset values immediately (asynchronous).
  - The in-flight packet is abandoned and no completed pulse is generated.
  - The upstream buffer shares `rst_n` and is cleared too.

## Structure
- `drain_state_t` enum (IDLE/STREAM/DONE/DISCARD) goes in `packet_types`.
- `MAX_FLIT_NUM` is shared with `packet_element_t.buffer` sizing in `packet_types`.
- One natural sub-module, `sat_counter` (parameter WIDTH; inputs inc and clear; output count, saturating). It is instantiated twice.
- Datapath (idx/len/out_flit registers) and FSM live in `packet_drain`.

## Test plan
- **3-flit packet:** tail_index=3, is_complete=1, ready high, valid at cycle 0 -> flits buffer[0..2] at cycles 1–3; last=1 only at cycle 3; completed pulse at cycle 4; drained_count=1.
- **Backpressure:** same packet with ready low at cycles 2–3 -> buffer[1] held stable cycles 2–4; buffer[2] at cycle 5 with last=1; completed at cycle 6; no duplicates or drops.
- **System packet:** tail_index=1 -> single beat at cycle 1 with last=1; completed at cycle 2.
- **Malformed packet:** tail_index=0 (then repeat with is_complete=0) -> no out_flit_valid; completed at cycle 1; discard_count=1, then 2.
- **Back-to-back packets:** two queued 2-flit packets (ids 5, 6), ready high -> id 5 beats at cycles 1–2, completed at 3; id 6 beats at cycles 5–6 with out_packet_id=6, completed at 7; drained_count=2.
- **Reset and saturation:**
  - rst_n low at cycle 2 of a 4-flit stream -> all outputs 0 asynchronously; no completed pulse; after release the FSM is IDLE.
  - 2^16+3 discards -> discard_count=16'hFFFF.

Source files
------------

// File: rtl/packet_drain_pkg.sv
// Shared flit/packet types for the reassembly buffer and its drain stage.
// The drain FSM encoding lives next to the packet element it consumes.
package types;
    localparam int FLIT_WIDTH      = 32;
    localparam int PACKET_ID_WIDTH = 8;

    typedef logic [FLIT_WIDTH-1:0]      flit_t;
    typedef logic [PACKET_ID_WIDTH-1:0] packet_id_t;
endpackage

package packet_types;
    import types::*;

    localparam int MAX_FLIT_NUM = 8;
    localparam int BUF_IW       = $clog2(MAX_FLIT_NUM);
    localparam int TAIL_WIDTH   = $clog2(MAX_FLIT_NUM + 1);

    typedef struct packed {
        flit_t [MAX_FLIT_NUM-1:0] buffer;
        logic [TAIL_WIDTH-1:0]    tail_index;
        packet_id_t               packet_id;
        logic                     is_complete;
    } packet_element_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STREAM  = 2'd1,
        DONE    = 2'd2,
        DISCARD = 2'd3
    } drain_state_t;

    // A packet may be streamed only if it is complete and holds 1..max_flits flits.
    function automatic logic is_drainable(input packet_element_t p, input int max_flits);
        return p.is_complete
            && (p.tail_index != {TAIL_WIDTH{1'b0}})
            && (int'(p.tail_index) <= max_flits);
    endfunction
endpackage

// File: rtl/packet_drain_if.sv
// Buffer-side and core-side handshake bundle of the packet drain stage.
interface packet_drain_if;
    import types::*;
    import packet_types::*;

    packet_element_t transfered_packet;
    logic            transfered_packet_valid;
    logic            transfered_packet_completed;
    flit_t           out_flit;
    logic            out_flit_valid;
    logic            out_flit_ready;
    logic            out_flit_last;
    packet_id_t      out_packet_id;

    modport master (
        output transfered_packet, transfered_packet_valid, out_flit_ready,
        input  transfered_packet_completed, out_flit, out_flit_valid,
        input  out_flit_last, out_packet_id
    );

    modport slave (
        input  transfered_packet, transfered_packet_valid, out_flit_ready,
        output transfered_packet_completed, out_flit, out_flit_valid,
        output out_flit_last, out_packet_id
    );
endinterface

// File: rtl/packet_drain_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

    // Count events, holding once the maximum is reached.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {WIDTH{1'b0}};
        end else if (clear) begin
            count <= {WIDTH{1'b0}};
        end else if (inc && (count != ALL_ONES)) begin
            count <= count + ONE;
        end else begin
            count <= count;
        end
    end
endmodule

// File: rtl/packet_drain.sv
// Streams the head completed packet flit-by-flit to the core side, then frees it;
// malformed or incomplete entries are dropped and counted.
module packet_drain
    import types::*;
    import packet_types::*;
#(
    parameter int MAX_FLITS   = MAX_FLIT_NUM,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   nocclk,
    input  logic                   rst_n,
    packet_drain_if.slave          bus,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] drained_count,
    output logic [COUNT_WIDTH-1:0] discard_count
);
    localparam int IW = $clog2(MAX_FLITS + 1);
    localparam logic [IW-1:0]     IDX_ZERO  = {IW{1'b0}};
    localparam logic [IW-1:0]     IDX_ONE   = {{(IW-1){1'b0}}, 1'b1};
    localparam logic [BUF_IW-1:0] BUF_FIRST = {BUF_IW{1'b0}};

    drain_state_t  state_r;
    logic [IW-1:0] idx_r;
    logic [IW-1:0] len_r;
    logic [IW-1:0] idx_next_s;
    logic [IW-1:0] tail_s;
    flit_t         flit_r;
    logic          valid_r;
    logic          last_r;
    packet_id_t    id_r;

    assign idx_next_s = idx_r + IDX_ONE;
    assign tail_s     = IW'(bus.transfered_packet.tail_index);

    // Drain FSM and flit datapath; the buffer entry is read in place, no copy is kept.
    always_ff @(posedge nocclk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
            len_r   <= IDX_ZERO;
            flit_r  <= {FLIT_WIDTH{1'b0}};
            valid_r <= 1'b0;
            last_r  <= 1'b0;
            id_r    <= {PACKET_ID_WIDTH{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.transfered_packet_valid) begin
                        if (is_drainable(bus.transfered_packet, MAX_FLITS)) begin
                            len_r   <= tail_s;
                            id_r    <= bus.transfered_packet.packet_id;
                            flit_r  <= bus.transfered_packet.buffer[BUF_FIRST];
                            idx_r   <= IDX_ZERO;
                            valid_r <= 1'b1;
                            last_r  <= (tail_s == IDX_ONE);
                            state_r <= STREAM;
                        end else begin
                            state_r <= DISCARD;
                        end
                    end
                end
                STREAM: begin
                    if (bus.out_flit_ready) begin
                        if (last_r) begin
                            valid_r <= 1'b0;
                            last_r  <= 1'b0;
                            state_r <= DONE;
                        end else begin
                            // Next beat is loaded on the accepting edge so beats run back-to-back.
                            idx_r  <= idx_next_s;
                            flit_r <= bus.transfered_packet.buffer[BUF_IW'(idx_next_s)];
                            last_r <= (idx_next_s == (len_r - IDX_ONE));
                        end
                    end
                end
                DONE:    state_r <= IDLE;
                DISCARD: state_r <= IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus.out_flit                    = flit_r;
    assign bus.out_flit_valid              = valid_r;
    assign bus.out_flit_last               = last_r;
    assign bus.out_packet_id               = id_r;
    assign bus.transfered_packet_completed = (state_r == DONE) || (state_r == DISCARD);
    assign busy                            = (state_r != IDLE);

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_drained (
        .clk   (nocclk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (state_r == DONE),
        .count (drained_count)
    );

    sat_counter #(.WIDTH(COUNT_WIDTH)) u_discard (
        .clk   (nocclk),
        .rst_n (rst_n),
        .clear (1'b0),
        .inc   (state_r == DISCARD),
        .count (discard_count)
    );
endmodule

// File: tb/tb_packet_drain.sv
// Randomized bench for packet_drain: each packet's expected beat stream, timing and
// counter totals are derived from the packet contents and the drain rules.
module tb_packet_drain;
    import types::*;
    import packet_types::*;

    localparam int MAXF = MAX_FLIT_NUM;
    localparam int CW   = 8;

    logic          nocclk = 1'b0;
    logic          rst_n  = 1'b0;
    logic          busy;
    logic [CW-1:0] drained_count;
    logic [CW-1:0] discard_count;

    packet_drain_if ifc();

    packet_drain #(.MAX_FLITS(MAXF), .COUNT_WIDTH(CW)) dut (
        .nocclk        (nocclk),
        .rst_n         (rst_n),
        .bus           (ifc),
        .busy          (busy),
        .drained_count (drained_count),
        .discard_count (discard_count)
    );

    always #5 nocclk = ~nocclk;

    int cyc = 0;
    always @(posedge nocclk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int exp_drained = 0;
    int exp_discard = 0;
    int first_abs;
    int comp_abs;

    function automatic int sat_inc(input int v);
        return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
    endfunction

    function automatic packet_element_t make_pkt(input int tail, input bit complete, input int id);
        packet_element_t p;
        for (int i = 0; i < MAXF; i++) p.buffer[BUF_IW'(i)] = $urandom;
        p.tail_index  = TAIL_WIDTH'(tail);
        p.packet_id   = PACKET_ID_WIDTH'(id);
        p.is_complete = complete;
        return p;
    endfunction

    // Presents one packet and follows it to its completed pulse. Ready is low for
    // relative cycles lo..hi, or random when rnd is set.
    task automatic stream_packet(input packet_element_t p, input int lo, input int hi, input bit rnd);
        int    tail, n, beat, last_c;
        bit    ok, seen, stalled, held_last, rdy;
        flit_t held, want;
        tail = int'(p.tail_index);
        ok   = p.is_complete && (tail >= 1) && (tail <= MAXF);
        n    = ok ? tail : 0;
        beat = 0; last_c = 0; seen = 0; stalled = 0; held_last = 0; held = '0;
        first_abs = -1;
        @(negedge nocclk);
        ifc.transfered_packet       = p;
        ifc.transfered_packet_valid = 1'b1;
        ifc.out_flit_ready          = 1'b1;
        for (int c = 1; c <= 200 && !seen; c++) begin
            @(negedge nocclk);
            if (ifc.transfered_packet_completed) begin
                seen = 1; comp_abs = cyc;
                tests++;
                if (c != (ok ? last_c + 1 : 1)) begin
                    fails++; $display("FAIL completed_cycle: got %0d expected %0d", c, ok ? last_c + 1 : 1);
                end
                tests++;
                if (ifc.out_flit_valid !== 1'b0) begin
                    fails++; $display("FAIL valid_at_completed: got %b expected 0", ifc.out_flit_valid);
                end
                tests++;
                if (beat != n) begin
                    fails++; $display("FAIL beat_count: got %0d expected %0d", beat, n);
                end
                ifc.transfered_packet_valid = 1'b0;
                if (ok) exp_drained = sat_inc(exp_drained);
                else    exp_discard = sat_inc(exp_discard);
            end else if (ifc.out_flit_valid === 1'b1) begin
                tests++;
                if (!ok || beat >= n) begin
                    fails++; $display("FAIL unexpected_beat: got beat %0d expected %0d beats", beat, n);
                end
                if (first_abs < 0) begin
                    first_abs = cyc;
                    tests++;
                    if (c != 1) begin
                        fails++; $display("FAIL first_beat_latency: got %0d expected 1", c);
                    end
                end
                if (stalled) begin
                    tests++;
                    if (ifc.out_flit !== held || ifc.out_flit_last !== held_last) begin
                        fails++; $display("FAIL stall_stable: got %h/%b expected %h/%b",
                                          ifc.out_flit, ifc.out_flit_last, held, held_last);
                    end
                end
                tests++;
                if (ifc.out_packet_id !== p.packet_id) begin
                    fails++; $display("FAIL packet_id: got %0d expected %0d", ifc.out_packet_id, p.packet_id);
                end
                rdy = rnd ? ($urandom_range(0, 3) != 0) : !(c >= lo && c <= hi);
                ifc.out_flit_ready = rdy;
                if (rdy) begin
                    want = (beat < MAXF) ? p.buffer[BUF_IW'(beat)] : '0;
                    tests++;
                    if (ifc.out_flit !== want || ifc.out_flit_last !== (beat == n - 1)) begin
                        fails++; $display("FAIL beat_%0d: got %h/%b expected %h/%b", beat,
                                          ifc.out_flit, ifc.out_flit_last, want, (beat == n - 1));
                    end
                    beat++; last_c = c; stalled = 0;
                end else begin
                    stalled = 1; held = ifc.out_flit; held_last = ifc.out_flit_last;
                end
            end else begin
                tests++; fails++;
                $display("FAIL no_progress: cycle %0d got valid=0 completed=0 expected one of them", c);
            end
        end
        if (!seen) begin
            tests++; fails++;
            $display("FAIL completed_timeout: got no pulse expected one within 200 cycles");
            ifc.transfered_packet_valid = 1'b0;
        end
        ifc.out_flit_ready = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        tests++;
        if (ifc.out_flit !== '0 || ifc.out_flit_valid !== 1'b0 || ifc.out_flit_last !== 1'b0) begin
            fails++; $display("FAIL reset_flit: got %h/%b/%b expected 0/0/0",
                              ifc.out_flit, ifc.out_flit_valid, ifc.out_flit_last);
        end
        tests++;
        if (ifc.out_packet_id !== '0 || busy !== 1'b0 || ifc.transfered_packet_completed !== 1'b0) begin
            fails++; $display("FAIL reset_ctrl: got id %0d busy %b comp %b expected 0",
                              ifc.out_packet_id, busy, ifc.transfered_packet_completed);
        end
        tests++;
        if (drained_count !== '0 || discard_count !== '0) begin
            fails++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", drained_count, discard_count);
        end
        @(negedge nocclk);
        rst_n = 1'b1;
    endtask

    task automatic test_three_flit();
        stream_packet(make_pkt(3, 1'b1, 3), 0, -1, 1'b0);
        @(negedge nocclk);
        tests++;
        if (drained_count !== CW'(exp_drained) || busy !== 1'b0) begin
            fails++; $display("FAIL three_flit_count: got %0d busy %b expected %0d busy 0",
                              drained_count, busy, exp_drained);
        end
    endtask

    task automatic test_backpressure();
        stream_packet(make_pkt(3, 1'b1, 9), 2, 3, 1'b0);
        @(negedge nocclk);
        tests++;
        if (drained_count !== CW'(exp_drained)) begin
            fails++; $display("FAIL backpressure_count: got %0d expected %0d", drained_count, exp_drained);
        end
    endtask

    task automatic test_system_packet();
        stream_packet(make_pkt(1, 1'b1, 1), 0, -1, 1'b0);
        @(negedge nocclk);
        tests++;
        if (drained_count !== CW'(exp_drained)) begin
            fails++; $display("FAIL system_count: got %0d expected %0d", drained_count, exp_drained);
        end
    endtask

    task automatic test_malformed();
        stream_packet(make_pkt(0, 1'b1, 20), 0, -1, 1'b0);
        @(negedge nocclk);
        tests++;
        if (discard_count !== CW'(exp_discard)) begin
            fails++; $display("FAIL discard_tail0: got %0d expected %0d", discard_count, exp_discard);
        end
        stream_packet(make_pkt(2, 1'b0, 21), 0, -1, 1'b0);
        stream_packet(make_pkt(MAXF + 1, 1'b1, 22), 0, -1, 1'b0);
        stream_packet(make_pkt(MAXF, 1'b1, 23), 0, -1, 1'b0);
        @(negedge nocclk);
        tests++;
        if (discard_count !== CW'(exp_discard) || drained_count !== CW'(exp_drained)) begin
            fails++; $display("FAIL discard_mix: got %0d/%0d expected %0d/%0d",
                              discard_count, drained_count, exp_discard, exp_drained);
        end
    endtask

    task automatic test_back_to_back();
        int comp5;
        stream_packet(make_pkt(2, 1'b1, 5), 0, -1, 1'b0);
        comp5 = comp_abs;
        stream_packet(make_pkt(2, 1'b1, 6), 0, -1, 1'b0);
        tests++;
        if (first_abs != comp5 + 2 || comp_abs != comp5 + 4) begin
            fails++; $display("FAIL back_to_back_timing: got %0d/%0d expected %0d/%0d",
                              first_abs, comp_abs, comp5 + 2, comp5 + 4);
        end
        @(negedge nocclk);
        tests++;
        if (drained_count !== CW'(exp_drained)) begin
            fails++; $display("FAIL back_to_back_count: got %0d expected %0d", drained_count, exp_drained);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 30; k++) begin
            stream_packet(make_pkt($urandom_range(0, MAXF + 3), ($urandom_range(0, 5) != 0),
                                   $urandom_range(0, 255)), 0, -1, 1'b1);
            @(negedge nocclk);
            tests++;
            if (drained_count !== CW'(exp_drained) || discard_count !== CW'(exp_discard)) begin
                fails++; $display("FAIL random_counts_%0d: got %0d/%0d expected %0d/%0d", k,
                                  drained_count, discard_count, exp_drained, exp_discard);
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge nocclk);
        ifc.transfered_packet       = make_pkt(4, 1'b1, 44);
        ifc.transfered_packet_valid = 1'b1;
        ifc.out_flit_ready          = 1'b1;
        @(negedge nocclk);
        @(negedge nocclk);
        #1 rst_n = 1'b0;
        #1;
        exp_drained = 0;
        exp_discard = 0;
        tests++;
        if (ifc.out_flit !== '0 || ifc.out_flit_valid !== 1'b0 || ifc.out_flit_last !== 1'b0
            || ifc.out_packet_id !== '0 || busy !== 1'b0) begin
            fails++; $display("FAIL async_reset_outputs: got %h/%b/%b/%0d/%b expected all 0",
                              ifc.out_flit, ifc.out_flit_valid, ifc.out_flit_last, ifc.out_packet_id, busy);
        end
        tests++;
        if (drained_count !== '0 || discard_count !== '0) begin
            fails++; $display("FAIL async_reset_counts: got %0d/%0d expected 0/0", drained_count, discard_count);
        end
        @(negedge nocclk);
        tests++;
        if (ifc.transfered_packet_completed !== 1'b0) begin
            fails++; $display("FAIL reset_no_completed: got %b expected 0", ifc.transfered_packet_completed);
        end
        ifc.transfered_packet_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge nocclk);
        tests++;
        if (busy !== 1'b0 || ifc.transfered_packet_completed !== 1'b0) begin
            fails++; $display("FAIL reset_release_idle: got busy %b comp %b expected 0/0",
                              busy, ifc.transfered_packet_completed);
        end
        stream_packet(make_pkt(4, 1'b1, 45), 0, -1, 1'b0);
    endtask

    task automatic test_saturation();
        for (int k = 0; k < (1 << CW) + 3; k++) begin
            stream_packet(make_pkt(0, 1'b1, k), 0, -1, 1'b0);
        end
        @(negedge nocclk);
        tests++;
        if (discard_count !== CW'(exp_discard) || exp_discard != (1 << CW) - 1) begin
            fails++; $display("FAIL discard_saturation: got %0d expected %0d", discard_count, (1 << CW) - 1);
        end
        tests++;
        if (drained_count !== CW'(exp_drained)) begin
            fails++; $display("FAIL saturation_drained: got %0d expected %0d", drained_count, exp_drained);
        end
    endtask

    initial begin
        ifc.transfered_packet       = '0;
        ifc.transfered_packet_valid = 1'b0;
        ifc.out_flit_ready          = 1'b1;
        test_reset();
        test_three_flit();
        test_backpressure();
        test_system_packet();
        test_malformed();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule
